// File: rtl/hwpe_cfg_target_if.sv
// hwpe_cfg_target_if: config bus between a requester and the target.
// Grant is same-cycle; the response follows one cycle later.
interface hwpe_cfg_target_if #(
    parameter int ID_WIDTH = 8
);
    logic                req_i;
    logic [31:0]         add_i;
    logic                wen_i;
    logic [3:0]          be_i;
    logic [31:0]         data_i;
    logic [ID_WIDTH-1:0] id_i;
    logic                gnt_o;
    logic [31:0]         r_data_o;
    logic                r_valid_o;
    logic [ID_WIDTH-1:0] r_id_o;

    modport master (
        output req_i,
        output add_i,
        output wen_i,
        output be_i,
        output data_i,
        output id_i,
        input  gnt_o,
        input  r_data_o,
        input  r_valid_o,
        input  r_id_o
    );

    modport slave (
        input  req_i,
        input  add_i,
        input  wen_i,
        input  be_i,
        input  data_i,
        input  id_i,
        output gnt_o,
        output r_data_o,
        output r_valid_o,
        output r_id_o
    );
endinterface

// File: rtl/hwpe_cfg_target.sv
// hwpe_cfg_target: job acquire/trigger/finish register target for an HWPE.
// Bus accesses are always granted; responses are registered one cycle later.
module hwpe_cfg_target #(
    parameter int N_CORES  = 8,
    parameter int ID_WIDTH = 8,
    parameter int N_REGS   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hwpe_cfg_target_if.slave         bus,
    output logic [N_REGS-1:0][31:0]  job_regs_o,
    output logic                     job_start_o,
    input  logic                     done_i,
    output logic                     busy_o,
    output logic [N_CORES-1:0][1:0]  evt_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRED,
        RUNNING
    } state_e;

    localparam logic [5:0] OFF_TRIGGER  = 6'h00;
    localparam logic [5:0] OFF_ACQUIRE  = 6'h01;
    localparam logic [5:0] OFF_FINISHED = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_RUN_ID   = 6'h04;
    localparam logic [5:0] OFF_SOFT_CLR = 6'h05;

    state_e                    state_q;
    state_e                    state_d;

    logic [7:0]                job_cnt_q;
    logic [7:0]                run_id_q;
    logic [31:0]               finished_q;
    logic [N_REGS-1:0][31:0]   regs_q;

    logic                      rvalid_q;
    logic [31:0]               rdata_q;
    logic [ID_WIDTH-1:0]       rid_q;
    logic                      job_start_q;
    logic                      evt_q;

    logic [5:0]                off;
    logic [3:0]                job_idx;
    logic                      rd;
    logic                      wr;

    logic                      hit_trig;
    logic                      hit_acq;
    logic                      hit_fin;
    logic                      hit_stat;
    logic                      hit_rid;
    logic                      hit_clr;
    logic                      hit_job;

    logic                      st_idle;
    logic                      st_acq;
    logic                      st_run;

    logic                      acq_fire;
    logic                      trig_fire;
    logic                      clr_fire;
    logic                      done_fire;
    logic                      job_wr;

    logic [31:0]               job_rd;
    logic [31:0]               rd_data;
    logic                      unused_add;

    // Only the word offset inside the 256-byte window is decoded.
    assign off        = bus.add_i[7:2];
    assign job_idx    = off[3:0];
    assign unused_add = ^{bus.add_i[31:8], bus.add_i[1:0]};

    assign rd = bus.req_i & bus.wen_i;
    assign wr = bus.req_i & ~bus.wen_i;

    assign hit_trig = (off == OFF_TRIGGER);
    assign hit_acq  = (off == OFF_ACQUIRE);
    assign hit_fin  = (off == OFF_FINISHED);
    assign hit_stat = (off == OFF_STATUS);
    assign hit_rid  = (off == OFF_RUN_ID);
    assign hit_clr  = (off == OFF_SOFT_CLR);
    assign hit_job  = (off[5:4] == 2'b01)
                    && (int'(job_idx) < N_REGS);

    // Qualified events; soft clear overrides a coincident done.
    assign acq_fire  = rd & hit_acq & st_idle;
    assign trig_fire = wr & hit_trig & st_acq;
    assign clr_fire  = wr & hit_clr;
    assign done_fire = done_i & st_run & ~clr_fire;
    assign job_wr    = wr & hit_job & st_acq;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; soft clear wins from any state.
    always_comb begin
        state_d = state_q;
        if (clr_fire) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (acq_fire) state_d = ACQUIRED;
                end
                ACQUIRED: begin
                    if (trig_fire) state_d = RUNNING;
                end
                RUNNING: begin
                    if (done_fire) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State-derived outputs and qualifiers.
    always_comb begin
        st_idle = 1'b0;
        st_acq  = 1'b0;
        st_run  = 1'b0;
        unique case (state_q)
            IDLE:     st_idle = 1'b1;
            ACQUIRED: st_acq  = 1'b1;
            RUNNING:  st_run  = 1'b1;
            default:  st_idle = 1'b1;
        endcase
    end

    assign busy_o = st_run;

    // Select the addressed job register for reads.
    always_comb begin
        job_rd = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (job_idx == 4'(i)) job_rd = regs_q[i];
        end
    end

    // Read mux, evaluated on pre-update state.
    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            hit_acq:  rd_data = st_idle ? {24'b0, job_cnt_q}
                                        : 32'hFFFF_FFFF;
            hit_fin:  rd_data = finished_q;
            hit_stat: rd_data = {31'b0, st_run};
            hit_rid:  rd_data = {24'b0, run_id_q};
            hit_job:  rd_data = job_rd;
            default:  rd_data = '0;
        endcase
    end

    // Job registers: byte-enabled writes only while acquired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (clr_fire) begin
            regs_q <= '0;
        end else if (job_wr) begin
            for (int i = 0; i < N_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (job_idx == 4'(i) && bus.be_i[b]) begin
                        regs_q[i][8*b +: 8] <= bus.data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Job ID counter and the ID latched for the running job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cnt_q <= '0;
            run_id_q  <= '0;
        end else if (clr_fire) begin
            job_cnt_q <= '0;
            run_id_q  <= '0;
        end else if (acq_fire) begin
            job_cnt_q <= job_cnt_q + 8'd1;
            run_id_q  <= job_cnt_q;
        end
    end

    // Finished-job counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finished_q <= '0;
        end else if (clr_fire) begin
            finished_q <= '0;
        end else if (done_fire) begin
            finished_q <= finished_q + 32'd1;
        end
    end

    // Engine start pulse and completion event pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_start_q <= 1'b0;
            evt_q       <= 1'b0;
        end else begin
            job_start_q <= trig_fire & ~clr_fire;
            evt_q       <= done_fire;
        end
    end

    // Bus response, one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= bus.req_i;
            rdata_q  <= rd ? rd_data : '0;
            rid_q    <= bus.req_i ? bus.id_i : '0;
        end
    end

    // Broadcast the completion event; the second event line is unused.
    always_comb begin
        evt_o = '0;
        for (int c = 0; c < N_CORES; c++) begin
            evt_o[c] = {1'b0, evt_q};
        end
    end

    assign bus.gnt_o     = bus.req_i;
    assign bus.r_valid_o = rvalid_q;
    assign bus.r_data_o  = rdata_q;
    assign bus.r_id_o    = rid_q;
    assign job_regs_o    = regs_q;
    assign job_start_o   = job_start_q;

endmodule

// File: tb/tb_hwpe_cfg_target.sv
// tb_hwpe_cfg_target: directed checks of the job config target.
// Expected values are hand-computed constants.
module tb_hwpe_cfg_target;

    localparam int N_CORES  = 8;
    localparam int ID_WIDTH = 8;
    localparam int N_REGS   = 16;

    localparam logic [31:0] A_TRIG = 32'h00;
    localparam logic [31:0] A_ACQ  = 32'h04;
    localparam logic [31:0] A_FIN  = 32'h08;
    localparam logic [31:0] A_STAT = 32'h0C;
    localparam logic [31:0] A_RID  = 32'h10;
    localparam logic [31:0] A_CLR  = 32'h14;
    localparam logic [31:0] A_JOB0 = 32'h40;
    localparam logic [31:0] A_JOB1 = 32'h44;
    localparam logic [31:0] EVT_ON = 32'h5555;

    logic                     clk;
    logic                     rst_n;
    logic [N_REGS-1:0][31:0]  job_regs;
    logic                     job_start;
    logic                     done;
    logic                     busy;
    logic [N_CORES-1:0][1:0]  evt;

    int checks;
    int failures;

    logic [31:0] r;

    hwpe_cfg_target_if #(.ID_WIDTH(ID_WIDTH)) bus ();

    hwpe_cfg_target #(
        .N_CORES  (N_CORES),
        .ID_WIDTH (ID_WIDTH),
        .N_REGS   (N_REGS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .job_regs_o  (job_regs),
        .job_start_o (job_start),
        .done_i      (done),
        .busy_o      (busy),
        .evt_o       (evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One granted access; returns the response data.
    task automatic xfer(input logic        w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  b,
                        input logic [7:0]  id,
                        input logic        dn,
                        output logic [31:0] rdat);
        bus.req_i  = 1'b1;
        bus.wen_i  = w;
        bus.add_i  = a;
        bus.data_i = d;
        bus.be_i   = b;
        bus.id_i   = id;
        done       = dn;
        #1;
        chk("gnt", {31'b0, bus.gnt_o}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_i  = 1'b0;
        bus.wen_i  = 1'b0;
        bus.add_i  = '0;
        bus.data_i = '0;
        bus.be_i   = '0;
        bus.id_i   = '0;
        done       = 1'b0;
        chk("r_valid", {31'b0, bus.r_valid_o}, 32'd1);
        chk("r_id", {24'b0, bus.r_id_o}, {24'b0, id});
        rdat = bus.r_data_o;
        if (!w) chk("wr_rdata", rdat, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a,
                      input logic [7:0]  id,
                      output logic [31:0] rdat);
        xfer(1'b1, a, 32'd0, 4'h0, id, 1'b0, rdat);
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  b);
        logic [31:0] unused_r;
        xfer(1'b0, a, d, b, 8'h0, 1'b0, unused_r);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        done       = 1'b0;
        bus.req_i  = 1'b0;
        bus.wen_i  = 1'b0;
        bus.add_i  = '0;
        bus.data_i = '0;
        bus.be_i   = '0;
        bus.id_i   = '0;

        // Reset state; grant still follows request.
        tick();
        tick();
        bus.req_i = 1'b1;
        #1;
        chk("rst_gnt", {31'b0, bus.gnt_o}, 32'd1);
        tick();
        chk("rst_rvalid", {31'b0, bus.r_valid_o}, 32'd0);
        chk("rst_rdata", bus.r_data_o, 32'd0);
        chk("rst_rid", {24'b0, bus.r_id_o}, 32'd0);
        chk("rst_start", {31'b0, job_start}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_evt", {16'b0, evt}, 32'd0);
        chk("rst_job0", job_regs[0], 32'd0);
        bus.req_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // Acquire, then re-acquire is refused.
        rd(A_ACQ, 8'h05, r);
        chk("acq0", r, 32'h0);
        tick();
        chk("rvalid_drop", {31'b0, bus.r_valid_o}, 32'd0);
        chk("rdata_idle", bus.r_data_o, 32'd0);
        rd(A_ACQ, 8'h06, r);
        chk("acq_busy", r, 32'hFFFF_FFFF);
        rd(A_RID, 8'h07, r);
        chk("run_id0", r, 32'h0);

        // Byte-enabled job register write while acquired.
        wr(A_JOB0, 32'hAABB_CCDD, 4'b0101);
        chk("job0_be", job_regs[0], 32'h00BB_00DD);
        rd(A_JOB0, 8'h08, r);
        chk("job0_rd", r, 32'h00BB_00DD);
        rd(32'h30, 8'h09, r);
        chk("unmapped", r, 32'h0);

        // Trigger starts the job.
        wr(A_TRIG, 32'h0, 4'hF);
        chk("start_pulse", {31'b0, job_start}, 32'd1);
        chk("busy_run", {31'b0, busy}, 32'd1);
        tick();
        chk("start_end", {31'b0, job_start}, 32'd0);
        rd(A_STAT, 8'h0A, r);
        chk("status_run", r, 32'h1);
        wr(A_TRIG, 32'h0, 4'hF);
        chk("retrig", {31'b0, job_start}, 32'd0);
        wr(A_JOB0, 32'hFFFF_FFFF, 4'hF);
        chk("job0_run", job_regs[0], 32'h00BB_00DD);

        // Done while running.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("evt_on", {16'b0, evt}, EVT_ON);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        tick();
        chk("evt_off", {16'b0, evt}, 32'd0);
        rd(A_FIN, 8'h0B, r);
        chk("fin1", r, 32'h1);
        rd(32'h108, 8'h0C, r);
        chk("fin_alias", r, 32'h1);
        wr(A_JOB0, 32'h1111_1111, 4'hF);
        chk("job0_idle", job_regs[0], 32'h00BB_00DD);
        rd(A_ACQ, 8'h0D, r);
        chk("acq1", r, 32'h1);

        // Done outside RUNNING is ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("evt_ign", {16'b0, evt}, 32'd0);
        rd(A_FIN, 8'h0E, r);
        chk("fin_ign", r, 32'h1);

        // STATUS read coincident with done returns pre-update value.
        wr(A_TRIG, 32'h0, 4'hF);
        xfer(1'b1, A_STAT, 32'h0, 4'h0, 8'h0F, 1'b1, r);
        chk("status_done", r, 32'h1);
        chk("evt_done2", {16'b0, evt}, EVT_ON);
        chk("busy_done2", {31'b0, busy}, 32'd0);
        rd(A_FIN, 8'h10, r);
        chk("fin2", r, 32'h2);

        // Soft clear coincident with done while running.
        rd(A_ACQ, 8'h11, r);
        chk("acq2", r, 32'h2);
        wr(A_JOB1, 32'h1234_5678, 4'hF);
        chk("job1", job_regs[1], 32'h1234_5678);
        wr(A_TRIG, 32'h0, 4'hF);
        xfer(1'b0, A_CLR, 32'h0, 4'hF, 8'h12, 1'b1, r);
        chk("clr_evt", {16'b0, evt}, 32'd0);
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_job0", job_regs[0], 32'd0);
        chk("clr_job1", job_regs[1], 32'd0);
        rd(A_FIN, 8'h13, r);
        chk("clr_fin", r, 32'h0);
        rd(A_RID, 8'h14, r);
        chk("clr_rid", r, 32'h0);
        rd(A_ACQ, 8'h15, r);
        chk("clr_acq", r, 32'h0);

        // Back-to-back reads with ids 1,2,3.
        bus.req_i = 1'b1;
        bus.wen_i = 1'b1;
        bus.add_i = A_STAT;
        bus.id_i  = 8'd1;
        tick();
        chk("b2b_v1", {31'b0, bus.r_valid_o}, 32'd1);
        chk("b2b_id1", {24'b0, bus.r_id_o}, 32'd1);
        bus.id_i = 8'd2;
        tick();
        chk("b2b_v2", {31'b0, bus.r_valid_o}, 32'd1);
        chk("b2b_id2", {24'b0, bus.r_id_o}, 32'd2);
        bus.id_i = 8'd3;
        tick();
        chk("b2b_v3", {31'b0, bus.r_valid_o}, 32'd1);
        chk("b2b_id3", {24'b0, bus.r_id_o}, 32'd3);
        bus.req_i = 1'b0;
        bus.wen_i = 1'b0;
        bus.id_i  = '0;
        tick();
        chk("b2b_end", {31'b0, bus.r_valid_o}, 32'd0);

        // Reset while running aborts the job.
        wr(A_TRIG, 32'h0, 4'hF);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_start", {31'b0, job_start}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_start", {31'b0, job_start}, 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("post_evt", {16'b0, evt}, 32'd0);
        rd(A_STAT, 8'h16, r);
        chk("post_status", r, 32'h0);
        rd(A_ACQ, 8'h17, r);
        chk("post_acq", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hwpe_cfg_target.md
HWPE_CFG_TARGET -- requirements
Module: hwpe_cfg_target

Interface
REQ-001 Parameters: N_CORES, default 8, number of event destinations; ID_WIDTH, default 8, transaction ID width; N_REGS, default 16, job registers (max 16).
REQ-002 Ports: clk  in  1  clock; rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 Ports: req_i  in  1  request; add_i  in  32  byte address; wen_i  in  1  1=read, 0=write; be_i  in  4  byte enables; data_i  in  32  write data; id_i  in  ID_WIDTH  requester ID.
REQ-004 Ports: gnt_o  out  1  grant; r_data_o  out  32  read data; r_valid_o  out  1  response valid; r_id_o  out  ID_WIDTH  response ID.
REQ-005 Ports: job_regs_o  out  N_REGS x 32  job register contents; job_start_o  out  1  engine start pulse; done_i  in  1  engine done pulse; busy_o  out  1  job running; evt_o  out  N_CORES x 2  per-core events.

Function
REQ-006 gnt_o SHALL equal req_i combinationally; every request is accepted in its cycle, no back-pressure.
REQ-007 For each granted request, r_valid_o SHALL assert exactly one cycle later for one cycle, with r_id_o = the registered id_i.
REQ-008 r_data_o SHALL carry read data for granted reads and 0 for granted writes; 0 when r_valid_o is low.
REQ-009 Decode SHALL use add_i[7:2] only: 0x00 TRIGGER, 0x04 ACQUIRE, 0x08 FINISHED, 0x0C STATUS, 0x10 RUNNING_ID, 0x14 SOFT_CLEAR, 0x40+4*i job reg i (i < N_REGS).
REQ-010 Unmapped offsets SHALL read 0; writes to them are ignored but still granted and responded.
REQ-011 FSM states: IDLE, ACQUIRED, RUNNING.
REQ-012 ACQUIRE read in IDLE: return zero-extended 8-bit job counter, latch it into RUNNING_ID, go to ACQUIRED, increment counter (wraps 255->0).
REQ-013 ACQUIRE read in ACQUIRED or RUNNING: return 0xFFFFFFFF, no state change.
REQ-014 Job register writes SHALL apply per byte per be_i only in ACQUIRED; ignored in IDLE and RUNNING; reads are allowed in any state.
REQ-015 TRIGGER write (any data) in ACQUIRED: go to RUNNING; job_start_o pulses high for exactly the following cycle; TRIGGER in IDLE or RUNNING is ignored.
REQ-016 busy_o SHALL be 1 exactly while in RUNNING.
REQ-017 done_i in RUNNING: go to IDLE next cycle; FINISHED increments (32-bit, wraps); evt_o[c][0] pulses 1 cycle for all c the cycle after done_i; evt_o[c][1] stays 0.
REQ-018 done_i outside RUNNING SHALL be ignored (no event, no count).
REQ-019 STATUS read SHALL return {31'b0, busy_o}; FINISHED read returns the counter; RUNNING_ID read returns the latched ID.
REQ-020 SOFT_CLEAR write in any state: next cycle go to IDLE, zero job regs, job counter, FINISHED, RUNNING_ID; cancel any pending job_start_o; the write's response is still produced.
REQ-021 SOFT_CLEAR coincident with done_i: clear wins; no event, FINISHED stays 0.
REQ-022 done_i in the same cycle as a granted access: both take effect; a STATUS read in that cycle returns 1 (pre-update value).

Reset
REQ-023 On rst_n low, asynchronously: state IDLE; gnt_o follows req_i; r_valid_o, job_start_o, busy_o, evt_o, r_data_o, r_id_o = 0; job regs, counters, RUNNING_ID = 0.
REQ-024 Reset during RUNNING SHALL abort the job with no event and no job_start_o after release.

Verification
REQ-025 Reset, read ACQUIRE id=0x5 -> r_valid 1 cycle later, r_data 0x0, r_id 0x5; second ACQUIRE -> 0xFFFFFFFF.
REQ-026 ACQUIRED, write 0x40 data 0xAABBCCDD be 0b0101 over 0 -> job_regs_o[0]=0x00BB00DD; same write in IDLE -> unchanged.
REQ-027 ACQUIRED, write TRIGGER -> job_start_o high 1 cycle next cycle, busy_o=1, STATUS reads 1; second TRIGGER -> no pulse.
REQ-028 RUNNING, pulse done_i -> next cycle all evt_o[c][0]=1 for 1 cycle, busy_o=0, FINISHED reads 1, ACQUIRE returns 0x1.
REQ-029 RUNNING, SOFT_CLEAR write with done_i same cycle -> IDLE, no event, FINISHED=0, job regs 0, ACQUIRE returns 0x0.
REQ-030 Back-to-back reads every cycle with ids 1,2,3 -> r_valid stays high 3 cycles, r_id 1,2,3 in order.
